// File: rtl/fft_frame_sched.sv
// Ping-pong frame scheduler feeding the 16-point FFT and pulsing the analysis stage once per frame.
// Optional OVF_CNT_EN adds a saturating dropped-sample counter output ovf_cnt.
module fft_frame_sched #(
  parameter int DW         = 16,
  parameter int N          = 16,
  parameter int NUM_FRAMES = 64,
  localparam int LOG2N     = $clog2(N),
  localparam int FCW       = $clog2(NUM_FRAMES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             buf_we,
  output logic [LOG2N:0]   buf_waddr,
  output logic [DW-1:0]    buf_wdata,
  output logic             fft_start,
  output logic             fft_bank,
  input  logic             fft_done,
  output logic             ana_start,
  output logic [FCW-1:0]   frame_cnt,
  output logic             done,
`ifdef OVF_CNT_EN
  output logic [7:0]       ovf_cnt,
`endif
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, START, RUN, FIN} state_t;

  state_t           state;
  logic             wr_bank;
  logic [LOG2N-1:0] wr_idx;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             rd_bank;
  logic             clr;
  logic             bank_free;
  logic             take;
  logic             drop;
  logic             last;

  // A bank released by fft_done on this edge is already free for the writer.
  always_comb begin
    clr       = (state == RUN) && fft_done;
    bank_free = !full[wr_bank] || (clr && (rd_bank == wr_bank));
    take      = in_valid && !done && bank_free;
    drop      = in_valid && !done && !bank_free;
    last      = (wr_idx == LOG2N'(N - 1));
    full_nxt  = full;
    if (clr) full_nxt[rd_bank] = 1'b0;
    if (take && last) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_we    <= 1'b0;
      buf_waddr <= '0;
      buf_wdata <= '0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      full      <= 2'b00;
      ovf       <= 1'b0;
    end else begin
      buf_we <= take;
      full   <= full_nxt;
      if (take) begin
        buf_waddr <= {wr_bank, wr_idx};
        buf_wdata <= in_data;
        if (last) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_idx  <= wr_idx + 1'b1;
        end
      end
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_bank   <= 1'b0;
      fft_start <= 1'b0;
      fft_bank  <= 1'b0;
      ana_start <= 1'b0;
      frame_cnt <= '0;
      done      <= 1'b0;
    end else begin
      fft_start <= 1'b0;
      ana_start <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rd_bank]) begin
            fft_start <= 1'b1;
            fft_bank  <= rd_bank;
            state     <= START;
          end
        end
        START: state <= RUN;
        RUN: begin
          if (fft_done) begin
            rd_bank   <= ~rd_bank;
            frame_cnt <= frame_cnt + 1'b1;
            ana_start <= 1'b1;
            if (frame_cnt == FCW'(NUM_FRAMES - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        FIN:     done  <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt <= 8'd0;
    end else if (drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed and randomized bench for fft_frame_sched; expected writes come from a sample-count address model.
module tb_fft_frame_sched;
  localparam int DW    = 16;
  localparam int N     = 16;
  localparam int NF    = 64;
  localparam int LOG2N = 4;
  localparam int FCW   = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             fft_done = 1'b0;
  logic             buf_we;
  logic [LOG2N:0]   buf_waddr;
  logic [DW-1:0]    buf_wdata;
  logic             fft_start;
  logic             fft_bank;
  logic             ana_start;
  logic [FCW-1:0]   frame_cnt;
  logic             done;
  logic             ovf;
`ifdef OVF_CNT_EN
  logic [7:0]       ovf_cnt;
`endif

  fft_frame_sched #(.DW(DW), .N(N), .NUM_FRAMES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .buf_we    (buf_we),
    .buf_waddr (buf_waddr),
    .buf_wdata (buf_wdata),
    .fft_start (fft_start),
    .fft_bank  (fft_bank),
    .fft_done  (fft_done),
    .ana_start (ana_start),
    .frame_cnt (frame_cnt),
    .done      (done),
`ifdef OVF_CNT_EN
    .ovf_cnt   (ovf_cnt),
`endif
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycnt = 0;
  int k = 0;
  int starts = 0;
  int anas = 0;
  int cd = 0;
  int done_cyc = -10;
  int t_start = 0;
  int t_ana = 0;
  bit auto_fft = 0;
  bit lat_rand = 0;
  bit chk_lat = 0;
  bit prev_last = 0;
  logic           exp_we = 1'b0;
  logic [LOG2N:0] exp_addr = '0;
  logic [DW-1:0]  exp_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clock: compare outputs just after the edge, then run the FFT responder.
  task automatic cycle();
    @(posedge clk);
    #1;
    cycnt++;
    chk("buf_we", buf_we, exp_we);
    if (exp_we) begin
      chk("buf_waddr", buf_waddr, exp_addr);
      chk("buf_wdata", buf_wdata, exp_data);
    end
    if (fft_start) begin
      if (chk_lat) chk("start_after_last_write", prev_last, 1);
      chk("fft_bank", fft_bank, starts % 2);
      starts++;
      t_start = cycnt;
      if (auto_fft) cd = lat_rand ? int'($urandom_range(1, 10)) : 10;
    end
    if (ana_start) begin
      anas++;
      t_ana = cycnt;
      chk("ana_after_done", cycnt, done_cyc + 1);
      chk("frame_cnt_at_ana", frame_cnt, anas);
    end
    prev_last = buf_we && (buf_waddr[LOG2N-1:0] == LOG2N'(N - 1));
    in_valid = 1'b0;
    fft_done = 1'b0;
    exp_we   = 1'b0;
    if (auto_fft && !fft_start && cd > 0) begin
      cd--;
      if (cd == 0) begin
        fft_done = 1'b1;
        done_cyc = cycnt;
      end
    end
  endtask

  task automatic send(input logic [DW-1:0] d, input bit acc);
    in_valid = 1'b1;
    in_data  = d;
    if (acc) begin
      exp_we   = 1'b1;
      exp_addr = (LOG2N+1)'(((k / N) % 2) * N + (k % N));
      exp_data = d;
      k++;
    end
    cycle();
  endtask

  task automatic clear_model();
    auto_fft = 0; lat_rand = 0; chk_lat = 0;
    cd = 0; k = 0; starts = 0; anas = 0; prev_last = 0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_buf_we"}, buf_we, 0);
    chk({pfx, "_buf_waddr"}, buf_waddr, 0);
    chk({pfx, "_buf_wdata"}, buf_wdata, 0);
    chk({pfx, "_fft_start"}, fft_start, 0);
    chk({pfx, "_fft_bank"}, fft_bank, 0);
    chk({pfx, "_ana_start"}, ana_start, 0);
    chk({pfx, "_frame_cnt"}, frame_cnt, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_ovf"}, ovf, 0);
`ifdef OVF_CNT_EN
    chk({pfx, "_ovf_cnt"}, ovf_cnt, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    cycle();
    cycle();
    check_zero("reset");
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();

    // One frame of 0x0001..0x0010, FFT answers 10 cycles after start
    auto_fft = 1; chk_lat = 1;
    for (int i = 1; i <= N; i++) send(DW'(i), 1);
    for (int j = 0; j < 40 && anas == 0; j++) cycle();
    chk("t1_ana_seen", anas, 1);
    chk("t1_start_to_ana", t_ana - t_start, 11);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_starts", starts, 1);

    // Both banks full with fft_done held off: next sample dropped
    do_reset();
    chk_lat = 1;
    for (int i = 0; i < 2 * N; i++) send(DW'($urandom), 1);
    send(16'h7777, 0);
    chk("t2_ovf", ovf, 1);
`ifdef OVF_CNT_EN
    chk("t2_ovf_cnt", ovf_cnt, 1);
`endif
    while (cycnt < t_start + 40) cycle();
    fft_done = 1'b1;
    done_cyc = cycnt;
    cycle();
    chk("t2_ana_start", ana_start, 1);
    chk("t2_frame_cnt", frame_cnt, 1);
    chk("t2_ovf_sticky", ovf, 1);

    // Sample lands in the same cycle fft_done frees its bank
    do_reset();
    for (int i = 0; i < 2 * N; i++) send(DW'($urandom), 1);
    repeat (3) cycle();
    fft_done = 1'b1;
    done_cyc = cycnt;
    send(16'h5A5A, 1);
    chk("t3_ovf", ovf, 0);
    cycle();
    chk("t3_next_start", fft_start, 1);
    chk("t3_next_bank", fft_bank, 1);

    // Full run: 1024 random samples with random gaps and FFT latency
    do_reset();
    auto_fft = 1; lat_rand = 1; chk_lat = 1;
    for (int i = 0; i < NF * N; i++) begin
      while ($urandom_range(0, 3) == 0) cycle();
      send(DW'($urandom), 1);
    end
    for (int j = 0; j < 300 && !done; j++) cycle();
    chk("t4_done", done, 1);
    chk("t4_starts", starts, NF);
    chk("t4_anas", anas, NF);
    chk("t4_frame_cnt", frame_cnt, NF);
    chk("t4_ovf", ovf, 0);
    for (int i = 0; i < 8; i++) send(DW'($urandom), 0);
    chk("t4_ovf_after_done", ovf, 0);
    chk("t4_done_held", done, 1);

    // Asynchronous reset mid-frame with FFT running
    do_reset();
    for (int i = 0; i < N + 7; i++) send(DW'($urandom), 1);
    #2;
    rst = 1'b1;
    #1;
    check_zero("midrst");
    clear_model();
    cycle();
    rst = 1'b0;
    send(16'hABCD, 1);
    chk("t5_ovf", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
